// File: rtl/bus_fifo_slave.sv
// Memory-mapped FIFO slave: masters push by writing DATA and pop by reading it.
// STATUS/CTRL expose fill level and sticky overflow/underflow and allow a flush.
module bus_fifo_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  s_sel,
  input  logic                  s_wr,
  input  logic [ADDR_WIDTH-1:0] s_address,
  input  logic [DATA_WIDTH-1:0] s_din,
  output logic [DATA_WIDTH-1:0] s_dout,
  output logic                  fifo_empty,
  output logic                  fifo_full
);

  localparam int PTR_W = CNT_WIDTH - 1;
  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);

  localparam logic [4:0] OFS_DATA   = 5'h00;
  localparam logic [4:0] OFS_STATUS = 5'h01;
  localparam logic [4:0] OFS_CTRL   = 5'h02;
  localparam logic [4:0] OFS_DEPTH  = 5'h03;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [DATA_WIDTH-1:0] s_dout_q, s_dout_d;
  logic                  push_en;
  logic [4:0]            offset;
  logic [DATA_WIDTH-1:0] status_word;
  logic                  unused_addr_hi;

  // Only the 32-byte window offset matters; the decoder already picked this slave.
  assign offset         = s_address[4:0];
  assign unused_addr_hi = ^s_address[ADDR_WIDTH-1:5];

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_C);
  assign s_dout     = s_dout_q;

  always_comb begin
    status_word                  = '0;
    status_word[0]               = fifo_empty;
    status_word[1]               = fifo_full;
    status_word[2]               = ovf_q;
    status_word[3]               = unf_q;
    status_word[8 +: CNT_WIDTH]  = count_q;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    s_dout_d = s_dout_q;
    push_en  = 1'b0;

    if (s_sel && s_wr) begin
      case (offset)
        OFS_DATA: begin
          if (fifo_full) begin
            ovf_d = 1'b1;
          end else begin
            push_en  = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            count_d  = count_q + CNT_WIDTH'(1);
          end
        end
        OFS_CTRL: begin
          // Flush leaves storage and s_dout untouched; only bookkeeping resets.
          if (s_din[0]) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
          end
          if (s_din[1]) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
          end
        end
        default: ;
      endcase
    end else if (s_sel) begin
      case (offset)
        OFS_DATA: begin
          if (fifo_empty) begin
            s_dout_d = '0;
            unf_d    = 1'b1;
          end else begin
            s_dout_d = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d  = count_q - CNT_WIDTH'(1);
          end
        end
        OFS_STATUS: s_dout_d = status_word;
        OFS_DEPTH:  s_dout_d = DATA_WIDTH'(DEPTH);
        default:    s_dout_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      s_dout_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      s_dout_q <= s_dout_d;
    end
  end

  // Storage has no reset; its contents are meaningless until pushed.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= s_din;
    end
  end

endmodule

// File: tb/tb_bus_fifo_slave.sv
// Bench for bus_fifo_slave: vector table, directed multi-cycle sequences and
// randomized traffic checked against a queue-based reference model.
module tb_bus_fifo_slave;

  logic        clk;
  logic        reset_n;
  logic        s_sel;
  logic        s_wr;
  logic [7:0]  s_address;
  logic [31:0] s_din;
  logic [31:0] s_dout;
  logic        fifo_empty;
  logic        fifo_full;

  int n_pass;
  int n_total;

  // Reference model state
  logic [31:0] exp_q[$];
  logic        m_ovf;
  logic        m_unf;
  logic [31:0] m_dout;

  bus_fifo_slave #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(8), .CNT_WIDTH(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .s_sel(s_sel), .s_wr(s_wr),
    .s_address(s_address), .s_din(s_din), .s_dout(s_dout),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] din;
    logic [31:0] exp_dout;
    logic        exp_empty;
    logic        exp_full;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // One bus access: inputs set at the falling edge, sampled at the rising edge,
  // task returns 1ns after that edge with s_sel dropped.
  task automatic access(input logic wr, input logic [7:0] addr, input logic [31:0] din);
    @(negedge clk);
    s_sel     = 1'b1;
    s_wr      = wr;
    s_address = addr;
    s_din     = din;
    @(posedge clk);
    #1;
    s_sel = 1'b0;
    s_wr  = 1'b0;
  endtask

  task automatic check_flags(input string name, input logic e, input logic f);
    check({name, "_empty"}, {31'd0, fifo_empty}, {31'd0, e});
    check({name, "_full"},  {31'd0, fifo_full},  {31'd0, f});
  endtask

  // Model: derived from the register rules with a queue
  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = (32'(exp_q.size()) << 8) | (32'(m_unf) << 3) | (32'(m_ovf) << 2)
      | (32'(exp_q.size() == 8) << 1) | 32'(exp_q.size() == 0);
    return s;
  endfunction

  task automatic model_apply(input logic wr, input logic [7:0] addr, input logic [31:0] din);
    logic [4:0] ofs;
    ofs = addr[4:0];
    if (wr) begin
      if (ofs == 5'h00) begin
        if (exp_q.size() == 8) m_ovf = 1'b1;
        else exp_q.push_back(din);
      end else if (ofs == 5'h02) begin
        if (din[0]) exp_q.delete();
        if (din[1]) begin m_ovf = 1'b0; m_unf = 1'b0; end
      end
    end else begin
      case (ofs)
        5'h00: begin
          if (exp_q.size() == 0) begin m_dout = 32'h0; m_unf = 1'b1; end
          else m_dout = exp_q.pop_front();
        end
        5'h01:   m_dout = model_status();
        5'h03:   m_dout = 32'd8;
        default: m_dout = 32'h0;
      endcase
    end
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    s_sel = 1'b0; s_wr = 1'b0; s_address = 8'h0; s_din = 32'h0;

    // Reset state
    reset_n = 1'b0;
    #12;
    check("rst_dout", s_dout, 32'h0);
    check_flags("rst", 1'b1, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    access(1'b0, 8'h01, 32'h0);
    check("rst_status", s_dout, 32'h001);

    // Vector table: push/pop three words, underflow, clear, misc registers
    vecs[0]  = '{1'b1, 8'h00, 32'h11, 32'h001, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'h00, 32'h22, 32'h001, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 8'h20, 32'h33, 32'h001, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'h01, 32'h0,  32'h300, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 32'h0,  32'h11,  1'b0, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 32'h0,  32'h22,  1'b0, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 32'h0,  32'h33,  1'b1, 1'b0};
    vecs[7]  = '{1'b0, 8'h01, 32'h0,  32'h001, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 32'h0,  32'h0,   1'b1, 1'b0};
    vecs[9]  = '{1'b0, 8'h01, 32'h0,  32'h009, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 8'h03, 32'h0,  32'h8,   1'b1, 1'b0};
    vecs[11] = '{1'b1, 8'h02, 32'h2,  32'h8,   1'b1, 1'b0};
    vecs[12] = '{1'b0, 8'h01, 32'h0,  32'h001, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 8'h02, 32'h0,  32'h0,   1'b1, 1'b0};
    vecs[14] = '{1'b0, 8'h10, 32'h0,  32'h0,   1'b1, 1'b0};
    vecs[15] = '{1'b1, 8'h05, 32'hFF, 32'h0,   1'b1, 1'b0};
    vecs[16] = '{1'b0, 8'h01, 32'h0,  32'h001, 1'b1, 1'b0};
    for (int i = 0; i < 17; i++) begin
      access(vecs[i].wr, vecs[i].addr, vecs[i].din);
      check($sformatf("vec%0d_dout", i), s_dout, vecs[i].exp_dout);
      check_flags($sformatf("vec%0d", i), vecs[i].exp_empty, vecs[i].exp_full);
    end

    // Fill past full with unf already set: STATUS = 0x80E
    access(1'b0, 8'h00, 32'h0);
    for (int i = 1; i <= 9; i++) begin
      access(1'b1, 8'h00, 32'(i));
      check_flags($sformatf("fill%0d", i), 1'b0, (i >= 8));
    end
    access(1'b0, 8'h01, 32'h0);
    check("full_status", s_dout, 32'h80E);
    for (int i = 1; i <= 8; i++) begin
      access(1'b0, 8'h00, 32'h0);
      check($sformatf("drain%0d", i), s_dout, 32'(i));
    end
    check_flags("drained", 1'b1, 1'b0);
    access(1'b1, 8'h02, 32'h2);
    access(1'b0, 8'h01, 32'h0);
    check("clr_status", s_dout, 32'h001);

    // Pointer wrap
    for (int i = 0; i < 6; i++) access(1'b1, 8'h00, 32'h100 + 32'(i));
    for (int i = 0; i < 6; i++) begin
      access(1'b0, 8'h00, 32'h0);
      check($sformatf("pre_wrap%0d", i), s_dout, 32'h100 + 32'(i));
    end
    for (int i = 0; i < 4; i++) access(1'b1, 8'h00, 32'hA + 32'(i));
    for (int i = 0; i < 4; i++) begin
      access(1'b0, 8'h00, 32'h0);
      check($sformatf("wrap%0d", i), s_dout, 32'hA + 32'(i));
    end

    // Flush keeps s_dout; combined flush+clear
    for (int i = 0; i < 3; i++) access(1'b1, 8'h00, 32'h70 + 32'(i));
    access(1'b1, 8'h02, 32'h1);
    check("flush_dout_kept", s_dout, 32'hD);
    check_flags("flush", 1'b1, 1'b0);
    access(1'b0, 8'h00, 32'h0);
    access(1'b1, 8'h00, 32'h44);
    access(1'b1, 8'h02, 32'h3);
    access(1'b0, 8'h01, 32'h0);
    check("flush_clr_status", s_dout, 32'h001);

    // Mid-cycle asynchronous reset
    access(1'b1, 8'h00, 32'h55);
    access(1'b0, 8'h01, 32'h0);
    check("pre_rst_status", s_dout, 32'h100);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_dout", s_dout, 32'h0);
    check_flags("async_rst", 1'b1, 1'b0);
    #2 reset_n = 1'b1;
    access(1'b0, 8'h01, 32'h0);
    check("post_rst_status", s_dout, 32'h001);
    access(1'b0, 8'h00, 32'h0);
    check("post_rst_pop", s_dout, 32'h0);
    access(1'b1, 8'h02, 32'h2);

    // Randomized traffic against the model
    exp_q.delete();
    m_ovf = 1'b0; m_unf = 1'b0; m_dout = s_dout;
    for (int n = 0; n < 300; n++) begin
      logic        wr;
      logic [7:0]  addr;
      logic [31:0] din;
      int r;
      r   = $urandom_range(0, 99);
      din = $urandom;
      if (r < 48)      begin wr = 1'b1; addr = ($urandom_range(0, 1) != 0) ? 8'h20 : 8'h00; end
      else if (r < 88) begin wr = 1'b0; addr = 8'h00; end
      else if (r < 94) begin wr = 1'b0; addr = 8'h01; end
      else if (r < 96) begin wr = 1'b0; addr = 8'(32'h03 + 32'($urandom_range(0, 1)) * 32'h20); end
      else             begin wr = 1'b1; addr = 8'h02; din = 32'($urandom_range(0, 3)); end
      model_apply(wr, addr, din);
      access(wr, addr, din);
      check($sformatf("rnd%0d_dout", n), s_dout, m_dout);
      check_flags($sformatf("rnd%0d", n), exp_q.size() == 0, exp_q.size() == 8);
    end
    access(1'b0, 8'h01, 32'h0);
    check("rnd_final_status", s_dout, model_status());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
